// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Packs opcode, register, function and immediate fields into a 32-bit RV32I
// instruction word. This is the inverse of the core's immediate extraction
// path. Each encoded word is held in a single output register behind a
// valid/ready handshake. The word is tagged with a sequential byte address
// and flagged when its immediate cannot be represented in the selected format.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   restart    synchronous; reloads the address counter, clears err_cnt
//   in_valid   input fields valid
//   in_ready   encoder can accept fields this cycle
//   opcode     7-bit instruction opcode
//   rd         destination register
//   rs1, rs2   source registers
//   funct3     funct3 field
//   funct7     funct7 field (R-type only)
//   imm        immediate in extended form (B/J in halfword units, U full)
//   out_valid  out_word valid
//   out_ready  consumer accepts out_word
//   out_word   encoded instruction
//   out_addr   byte address of out_word
//   out_err    immediate not representable, or illegal opcode
//   err_cnt    saturating count of emitted words with out_err set
// ---------------------------------------------------------------------------
module instr_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                ERR_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        opcode,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_word,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   logic              outValid_q, outValid_d;
   logic [31:0]       outWord_q,  outWord_d;
   logic              outErr_q,   outErr_d;
   logic [ADDR_W-1:0] addr_q,     addr_d;
   logic [ERR_W-1:0]  errCnt_q,   errCnt_d;

   logic [31:0] encWord;
   logic        encErr;
   logic        immFits12;
   logic        immFits20;
   logic        accept;
   logic        xfer;

   // An immediate fits a 12-bit (or 20-bit) signed field when every bit from
   // the field's sign bit upward is a copy of that sign bit.
   always_comb begin
      immFits12 = (&imm[31:11]) || !(|imm[31:11]);
      immFits20 = (&imm[31:19]) || !(|imm[31:19]);
   end

   // Format selection and bit packing. Out-of-range immediates are still
   // packed with their low bits so the loader can see what was truncated;
   // unknown opcodes collapse to a NOP so a bad image never executes garbage.
   always_comb begin
      encWord = NOP_WORD;
      encErr  = 1'b1;
      case (opcode)
         OP_R: begin
            encWord = {funct7, rs2, rs1, funct3, rd, opcode};
            encErr  = 1'b0;
         end
         OP_LOAD, OP_IMM, OP_JALR: begin
            encWord = {imm[11:0], rs1, funct3, rd, opcode};
            encErr  = !immFits12;
         end
         OP_STORE: begin
            encWord = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            encErr  = !immFits12;
         end
         OP_BRANCH: begin
            encWord = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
            encErr  = !immFits12;
         end
         OP_JAL: begin
            encWord = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
            encErr  = !immFits20;
         end
         OP_LUI, OP_AUIPC: begin
            encWord = {imm[31:12], rd, opcode};
            encErr  = |imm[11:0];
         end
         default: begin
            encWord = NOP_WORD;
            encErr  = 1'b1;
         end
      endcase
   end

   // Handshake: the single holding register can take a new word whenever it
   // is empty or is being emptied this same cycle, giving full throughput.
   always_comb begin
      in_ready = !outValid_q || out_ready;
      accept   = in_valid && in_ready;
      xfer     = outValid_q && out_ready;
   end

   // Next-state for the holding register. A simultaneous transfer and accept
   // simply reloads the register, so out_valid stays high.
   always_comb begin
      outValid_d = outValid_q;
      outWord_d  = outWord_q;
      outErr_d   = outErr_q;
      if (accept) begin
         outValid_d = 1'b1;
         outWord_d  = encWord;
         outErr_d   = encErr;
      end else if (xfer) begin
         outValid_d = 1'b0;
      end
   end

   // Address and error counters advance only on an output transfer. The
   // address wraps naturally at 2^ADDR_W; the error count sticks at all-ones.
   // restart wins over any advance in the same cycle but leaves the held
   // word alone.
   always_comb begin
      addr_d   = addr_q;
      errCnt_d = errCnt_q;
      if (xfer) begin
         addr_d = addr_q + ADDR_W'(4);
         if (outErr_q && !(&errCnt_q)) begin
            errCnt_d = errCnt_q + ERR_W'(1);
         end
      end
      if (restart) begin
         addr_d   = BASE_ADDR;
         errCnt_d = '0;
      end
   end

   // State registers with synchronous reset; reset drops any held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         outValid_q <= 1'b0;
         outWord_q  <= '0;
         outErr_q   <= 1'b0;
         addr_q     <= BASE_ADDR;
         errCnt_q   <= '0;
      end else begin
         outValid_q <= outValid_d;
         outWord_q  <= outWord_d;
         outErr_q   <= outErr_d;
         addr_q     <= addr_d;
         errCnt_q   <= errCnt_d;
      end
   end

   // Outputs come straight from the registers.
   always_comb begin
      out_valid = outValid_q;
      out_word  = outWord_q;
      out_err   = outErr_q;
      out_addr  = addr_q;
      err_cnt   = errCnt_q;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge, away from the active edge.
// A second instance with a 4-bit address and base 0xC exercises wrap-around.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        restart;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [31:0] out_addr;
   logic        out_err;
   logic [7:0]  err_cnt;

   logic        in_ready2;
   logic        out_valid2;
   logic [31:0] out_word2;
   logic [3:0]  out_addr2;
   logic        out_err2;
   logic [7:0]  err_cnt2;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .rst(rst), .restart(restart),
      .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_word(out_word), .out_addr(out_addr),
      .out_err(out_err), .err_cnt(err_cnt)
   );

   instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC), .ERR_W(8)) dutWrap (
      .clk(clk), .rst(rst), .restart(restart),
      .in_valid(in_valid), .in_ready(in_ready2),
      .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid2), .out_ready(out_ready),
      .out_word(out_word2), .out_addr(out_addr2),
      .out_err(out_err2), .err_cnt(err_cnt2)
   );

   // Present one set of fields with in_valid high (called at a falling edge).
   task automatic driveFields(input logic [6:0] op, input logic [4:0] rdV,
                              input logic [4:0] rs1V, input logic [4:0] rs2V,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] immV);
      opcode   = op;
      rd       = rdV;
      rs1      = rs1V;
      rs2      = rs2V;
      funct3   = f3;
      funct7   = f7;
      imm      = immV;
      in_valid = 1'b1;
   endtask

   // Pulse rst for one rising edge; returns at a falling edge with rst low.
   task automatic doReset();
      @(negedge clk);
      rst       = 1'b1;
      restart   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      compared++;
      if (out_valid !== 1'b0) begin
         $display("[TB] FAIL reset_valid: got %0b want 0", out_valid); mismatched++;
      end
      compared++;
      if (out_word !== 32'h0) begin
         $display("[TB] FAIL reset_word: got %h want 00000000", out_word); mismatched++;
      end
      compared++;
      if (out_addr !== 32'h0 || out_err !== 1'b0 || err_cnt !== 8'h0) begin
         $display("[TB] FAIL reset_counters: addr %h err %0b cnt %0d want 0/0/0",
                  out_addr, out_err, err_cnt); mismatched++;
      end
      compared++;
      if (in_ready !== 1'b1) begin
         $display("[TB] FAIL reset_ready: got %0b want 1", in_ready); mismatched++;
      end
   endtask

   task automatic test_addi();
      doReset();
      driveFields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      @(negedge clk);
      in_valid = 1'b0;
      compared++;
      if (out_valid !== 1'b1 || out_word !== 32'h00500093 || out_addr !== 32'h0 || out_err !== 1'b0) begin
         $display("[TB] FAIL addi: valid %0b word %h addr %h err %0b want 1/00500093/0/0",
                  out_valid, out_word, out_addr, out_err); mismatched++;
      end
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0 || out_addr !== 32'h4) begin
         $display("[TB] FAIL addi_drain: valid %0b addr %h want 0/4", out_valid, out_addr); mismatched++;
      end
   endtask

   task automatic test_back_to_back();
      doReset();
      driveFields(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
      @(negedge clk);
      compared++;
      if (out_word !== 32'h0020A423 || out_addr !== 32'h0 || in_ready !== 1'b1) begin
         $display("[TB] FAIL sw: word %h addr %h ready %0b want 0020a423/0/1",
                  out_word, out_addr, in_ready); mismatched++;
      end
      driveFields(7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFE);
      @(negedge clk);
      in_valid = 1'b0;
      compared++;
      if (out_word !== 32'hFE000EE3 || out_addr !== 32'h4 || in_ready !== 1'b1 || out_err !== 1'b0) begin
         $display("[TB] FAIL beq: word %h addr %h ready %0b err %0b want fe000ee3/4/1/0",
                  out_word, out_addr, in_ready, out_err); mismatched++;
      end
   endtask

   task automatic test_jal_lui();
      doReset();
      driveFields(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
      @(negedge clk);
      compared++;
      if (out_word !== 32'h008000EF || out_err !== 1'b0) begin
         $display("[TB] FAIL jal: word %h err %0b want 008000ef/0", out_word, out_err); mismatched++;
      end
      driveFields(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      @(negedge clk);
      in_valid = 1'b0;
      compared++;
      if (out_word !== 32'h123452B7 || out_err !== 1'b0 || out_addr !== 32'h4) begin
         $display("[TB] FAIL lui: word %h err %0b addr %h want 123452b7/0/4",
                  out_word, out_err, out_addr); mismatched++;
      end
   endtask

   task automatic test_other_formats();
      doReset();
      // sub x3,x1,x2
      driveFields(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF);
      @(negedge clk);
      compared++;
      if (out_word !== 32'h402081B3 || out_err !== 1'b0) begin
         $display("[TB] FAIL rtype: word %h err %0b want 402081b3/0", out_word, out_err); mismatched++;
      end
      // lui with low bits set is not representable
      driveFields(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001);
      @(negedge clk);
      compared++;
      if (out_word !== 32'h000000B7 || out_err !== 1'b1) begin
         $display("[TB] FAIL lui_err: word %h err %0b want 000000b7/1", out_word, out_err); mismatched++;
      end
      // jal offset just past the 20-bit signed range
      driveFields(7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0008_0000);
      @(negedge clk);
      in_valid = 1'b0;
      compared++;
      if (out_word !== 32'h8000006F || out_err !== 1'b1) begin
         $display("[TB] FAIL jal_err: word %h err %0b want 8000006f/1", out_word, out_err); mismatched++;
      end
   endtask

   task automatic test_errors();
      doReset();
      driveFields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      @(negedge clk);
      compared++;
      if (out_word !== 32'h80000093 || out_err !== 1'b1 || err_cnt !== 8'd0) begin
         $display("[TB] FAIL addi_range: word %h err %0b cnt %0d want 80000093/1/0",
                  out_word, out_err, err_cnt); mismatched++;
      end
      driveFields(7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 7'd1, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      compared++;
      if (out_word !== 32'h00000013 || out_err !== 1'b1 || err_cnt !== 8'd1) begin
         $display("[TB] FAIL illegal_op: word %h err %0b cnt %0d want 00000013/1/1",
                  out_word, out_err, err_cnt); mismatched++;
      end
      @(negedge clk);
      compared++;
      if (err_cnt !== 8'd2 || out_valid !== 1'b0) begin
         $display("[TB] FAIL err_cnt: cnt %0d valid %0b want 2/0", err_cnt, out_valid); mismatched++;
      end
   endtask

   task automatic test_saturation();
      doReset();
      driveFields(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      for (int i = 0; i < 260; i++) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      compared++;
      if (err_cnt !== 8'hFF) begin
         $display("[TB] FAIL err_sat: got %0d want 255", err_cnt); mismatched++;
      end
   endtask

   task automatic test_backpressure();
      doReset();
      out_ready = 1'b0;
      driveFields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b1 || out_word !== 32'h00500093 || in_ready !== 1'b0) begin
         $display("[TB] FAIL bp_first: valid %0b word %h ready %0b want 1/00500093/0",
                  out_valid, out_word, in_ready); mismatched++;
      end
      driveFields(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
      @(negedge clk);
      @(negedge clk);
      compared++;
      if (out_word !== 32'h00500093 || out_addr !== 32'h0 || out_err !== 1'b0 || in_ready !== 1'b0) begin
         $display("[TB] FAIL bp_hold: word %h addr %h err %0b ready %0b want 00500093/0/0/0",
                  out_word, out_addr, out_err, in_ready); mismatched++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      compared++;
      if (out_valid !== 1'b1 || out_word !== 32'h0020A423 || out_addr !== 32'h4) begin
         $display("[TB] FAIL bp_release: valid %0b word %h addr %h want 1/0020a423/4",
                  out_valid, out_word, out_addr); mismatched++;
      end
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0 || out_addr !== 32'h8) begin
         $display("[TB] FAIL bp_drain: valid %0b addr %h want 0/8", out_valid, out_addr); mismatched++;
      end
   endtask

   task automatic test_restart_and_rst();
      doReset();
      driveFields(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      driveFields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      compared++;
      if (out_addr !== 32'hC || err_cnt !== 8'd3 || out_word !== 32'h00500093) begin
         $display("[TB] FAIL pre_restart: addr %h cnt %0d word %h want c/3/00500093",
                  out_addr, err_cnt, out_word); mismatched++;
      end
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      compared++;
      if (out_addr !== 32'h0 || err_cnt !== 8'd0) begin
         $display("[TB] FAIL restart_counters: addr %h cnt %0d want 0/0", out_addr, err_cnt); mismatched++;
      end
      compared++;
      if (out_valid !== 1'b1 || out_word !== 32'h00500093 || out_err !== 1'b0) begin
         $display("[TB] FAIL restart_hold: valid %0b word %h err %0b want 1/00500093/0",
                  out_valid, out_word, out_err); mismatched++;
      end
      // reset while the consumer is stalled drops the held word
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      compared++;
      if (out_valid !== 1'b0 || out_word !== 32'h0 || out_addr !== 32'h0) begin
         $display("[TB] FAIL rst_mid: valid %0b word %h addr %h want 0/0/0",
                  out_valid, out_word, out_addr); mismatched++;
      end
      out_ready = 1'b1;
   endtask

   task automatic test_addr_wrap();
      doReset();
      driveFields(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      @(negedge clk);
      compared++;
      if (out_addr2 !== 4'hC) begin
         $display("[TB] FAIL wrap_base: got %h want c", out_addr2); mismatched++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      compared++;
      if (out_addr2 !== 4'h0 || out_valid2 !== 1'b1) begin
         $display("[TB] FAIL wrap_addr: addr %h valid %0b want 0/1", out_addr2, out_valid2); mismatched++;
      end
   endtask

   initial begin
      rst       = 1'b1;
      restart   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      opcode    = '0;
      rd        = '0;
      rs1       = '0;
      rs2       = '0;
      funct3    = '0;
      funct7    = '0;
      imm       = '0;
      test_reset();
      test_addi();
      test_back_to_back();
      test_jal_lui();
      test_other_formats();
      test_errors();
      test_saturation();
      test_backpressure();
      test_restart_and_rst();
      test_addr_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate extraction path. Packs opcode, register, function and immediate fields into a 32-bit RV32I instruction word.
- Registers each word with a valid/ready handshake and tags it with a sequential instruction-memory byte address.
- Flags immediates that the selected format cannot represent.
- Used by the program loader and by self-checking benches to build instruction images.

Parameters:
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 32'h0000_0000, address of the first emitted word after reset or restart.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- restart  in  1  synchronous; reload address counter and clear error counter
- in_valid  in  1  input fields valid
- in_ready  out  1  encoder can accept fields this cycle
- opcode  in  7  instruction opcode
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (R-type only)
- imm  in  32  immediate in extended form; B and J are in halfword units (byte offset / 2); U is the full value with bits 11:0 zero
- out_valid  out  1  out_word valid
- out_ready  in  1  consumer accepts out_word
- out_word  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_word
- out_err  out  1  immediate not representable, or illegal opcode, for out_word
- err_cnt  out  ERR_W  saturating count of emitted words with out_err=1

Behaviour:
- Reset values: out_valid=0, out_word=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0.
- Handshake and holding:
  - Output is one holding register.
  - in_ready = !out_valid || out_ready (combinational).
  - Input accepted when in_valid && in_ready. The encoded word appears on out_word with out_valid=1 the next cycle; latency is 1.
  - Output transfer occurs when out_valid && out_ready.
  - Simultaneous transfer and accept: the register reloads and out_valid stays 1, giving full throughput.
  - While out_valid && !out_ready, out_word, out_addr and out_err are held stable.
- Address counter:
  - out_addr increments by 4 on every output transfer.
  - Wraps modulo 2^ADDR_W.
- Formats by opcode (word bits listed high to low):
  - R 0110011: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I 0000011/0010011/1100111: {imm[11:0], rs1, funct3, rd, opcode}.
  - S 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B 1100011: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode}.
  - J 1101111: {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode}.
  - U 0110111/0010111: {imm[31:12], rd, opcode}.
- out_err conditions:
  - I/S/B: imm[31:11] not all equal.
  - J: imm[31:19] not all equal.
  - U: imm[11:0] != 0.
  - R never errs.
  - Any other opcode: out_word = 32'h0000_0013 (NOP), out_err=1.
- On a range error the word is still emitted with truncated immediate bits.
- err_cnt:
  - Increments on each output transfer carrying out_err=1.
  - Saturates at all-ones.
- restart:
  - out_addr <= BASE_ADDR and err_cnt <= 0.
  - The held word, out_valid and the handshake are unaffected.
  - restart overrides any increment in the same cycle.
- rst mid-operation: the held word is dropped (out_valid=0) and all counters return to reset values.

Test Plan:
- Reset, then addi x1,x0,5 (opcode 0010011, rd=1, imm=5), out_ready=1 -> next cycle out_word=32'h00500093, out_addr=0, out_err=0.
- sw x2,8(x1), then beq x0,x0 with imm=32'hFFFFFFFE, back to back -> out_word 32'h0020A423 then 32'hFE000EE3, out_addr 0 then 4, in_ready stays 1.
- jal x1 with imm=4, then lui x5 with imm=32'h12345000 -> 32'h008000EF then 32'h123452B7.
- addi with imm=2048, then opcode 7'h7F -> 32'h80000093 with out_err=1, then 32'h00000013 with out_err=1; err_cnt=2 after both transfers.
- Backpressure: out_ready=0 with two valid inputs -> first word held stable, in_ready=0, second not accepted; raising out_ready -> second word appears next cycle, out_addr advances by 4.
- restart pulsed after 3 transfers (out_addr=0x0C) while a word is held -> out_addr=BASE_ADDR and err_cnt=0 next cycle, held word unchanged; rst mid-backpressure -> out_valid=0 next cycle.
